gvt_arbiter: RTL
================

# gvt_arbiter

Computes the Global Virtual Time (GVT) once every 2^LOG_GVT_PERIOD cycles: snapshots each tile's local virtual time (LVT), min-reduces the snapshot serially, and publishes the result. Sits between the per-tile commit queues, which supply LVTs, and the commit logic in every tile, which consumes the broadcast GVT to retire tasks.

## Interface
- N_TILES, default 1: number of LVT sources.
- TS_WIDTH, default 32: timestamp width.
- TB_WIDTH, default 32: tiebreaker width.
- LOG_GVT_PERIOD, default 5: log2 of the round period (32 cycles).
- Legal configuration requires N_TILES + 2 ≤ 2^LOG_GVT_PERIOD. Elaboration fails otherwise.

Ports:
- clk, in, 1: the only clock.
- rstn, in, 1: reset. Synchronous, active-low.
- enable, in, 1: host enable. When low, the period counter is held at 0 and no rounds start.
- lvt_valid, in, N_TILES: tile i has a live LVT. When low, tile i counts as infinity (all-ones).
- lvt_ts, in, N_TILES×TS_WIDTH: per-tile LVT timestamp.
- lvt_tb, in, N_TILES×TB_WIDTH: per-tile LVT tiebreaker.
- gvt_ts, out, TS_WIDTH: published GVT timestamp.
- gvt_tb, out, TB_WIDTH: published GVT tiebreaker.
- gvt_valid, out, 1: one-cycle pulse when the GVT is updated.
- all_idle, out, 1: the last published round found every tile invalid.
- gvt_err, out, 1: sticky monotonicity violation. Tied to 0 unless the check is compiled in.

## Operation
- A VT is the concatenation {ts, tb}, (TS_WIDTH+TB_WIDTH) bits wide, compared unsigned. Infinity is the all-ones value.
- Period counter `per_cnt`, LOG_GVT_PERIOD bits, increments every cycle while enable=1 and wraps. The *tick* is the cycle where per_cnt equals all-ones.
- The FSM has three states: IDLE, SCAN and PUBLISH.
- IDLE: on a tick, go to SCAN.
  - In that same cycle, snapshot all lvt_valid/lvt_ts/lvt_tb into registers.
  - Set acc = infinity and idx = 0.
- SCAN: each cycle, acc = min(acc, snap[idx]), where an invalid entry is treated as infinity.
  - idx increments each cycle.
  - After processing idx = N_TILES-1, go to PUBLISH.
  - Exactly N_TILES SCAN cycles are spent.
- PUBLISH: record the round result.
  - all_idle is set to 1 if acc is infinity, and to 0 otherwise.
  - When all_idle=1, the GVT is left unchanged and gvt_valid stays 0.
  - Otherwise gvt ← acc and gvt_valid=1 for one cycle, subject to the monotonic check described under Configuration.
  - Then return to IDLE.
- A tick that arrives outside IDLE is ignored. This cannot occur with a legal configuration, but it must still be handled safely.
- Dropping enable mid-round does not abort the round: the round in flight completes, and only the counter is held.
- Live lvt_* changes after the snapshot have no effect on the round in flight.

## Timing
- Reset values:
  - gvt_ts = 0, gvt_tb = 0, gvt_valid = 0, all_idle = 0, gvt_err = 0.
  - FSM = IDLE, per_cnt = 0.
- Latency: snapshot at tick cycle T. gvt_valid is asserted at T + N_TILES + 1. The new gvt_* values are visible from T + N_TILES + 2.
  - Example: N_TILES=1 gives snapshot at T, SCAN at T+1, PUBLISH at T+2.
- From enable rising with per_cnt=0, the first tick occurs 2^LOG_GVT_PERIOD − 1 cycles later.
- No back-pressure: consumers must sample on gvt_valid.
- rstn low in any state returns to IDLE on the next edge. A round in flight is discarded and no gvt_valid pulse is produced.

## Configuration
- GVT_MONOTONIC_CHECK_EN defined:
  - In PUBLISH, if acc < current gvt (and acc is not infinity), gvt holds its value and gvt_valid stays 0.
  - gvt_err is set and stays 1 until reset.
- GVT_MONOTONIC_CHECK_EN undefined:
  - gvt takes acc unconditionally whenever acc is not infinity.
  - gvt_err is constant 0 and no comparator is built.

## Test plan
- Test 1: reset, then enable=1, N_TILES=4, LOG_GVT_PERIOD=5, LVT ts = {40,12,99,17} with all tb=0 and all valid.
  - Required: gvt_valid at cycle 31+5 = 36 after enable; gvt_ts=12, gvt_tb=0.
- Test 2: tiebreak. ts = {7,7,7,7}, tb = {5,2,9,3}.
  - Required: gvt = {7,2}.
- Test 3: lvt_valid = 4'b0000.
  - Required: all_idle=1, no gvt_valid pulse, gvt unchanged.
  - Then set tile 2 valid with ts=50. Next round: all_idle=0, gvt_ts=50.
- Test 4: snapshot isolation. Change tile 1 from ts=12 to ts=1 one cycle after the tick.
  - Required: that round publishes 12; the following round publishes 1.
- Test 5 (macro on): publish gvt=100, then drive every tile to ts=60.
  - Required: gvt stays 100, no gvt_valid pulse, gvt_err=1 and remains set.
  - Macro off: gvt=60, gvt_err=0.
- Test 6: assert rstn=0 during SCAN.
  - Required: no gvt_valid pulse, outputs return to their reset values, the next round completes normally.

Source files
------------

// File: rtl/gvt_arbiter.sv
// gvt_arbiter: periodic Global Virtual Time computation.
// Once every 2^LOG_GVT_PERIOD cycles the per-tile local virtual times are
// snapshotted, min-reduced one tile per cycle, and the result is published
// as the GVT broadcast to every tile's commit logic.
// A virtual time is {ts, tb}, compared unsigned; all-ones means infinity.
// Optional feature macro: GVT_MONOTONIC_CHECK_EN, which rejects a round
// result lower than the current GVT and raises the sticky gvt_err flag.
module gvt_arbiter #(
    parameter int N_TILES        = 1,
    parameter int TS_WIDTH       = 32,
    parameter int TB_WIDTH       = 32,
    parameter int LOG_GVT_PERIOD = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic [N_TILES-1:0]           lvt_valid,
    input  logic [N_TILES*TS_WIDTH-1:0]  lvt_ts,
    input  logic [N_TILES*TB_WIDTH-1:0]  lvt_tb,
    output logic [TS_WIDTH-1:0]          gvt_ts,
    output logic [TB_WIDTH-1:0]          gvt_tb,
    output logic                         gvt_valid,
    output logic                         all_idle,
    output logic                         gvt_err
);

    localparam int VT_W  = TS_WIDTH + TB_WIDTH;
    localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    localparam logic [VT_W-1:0]  VT_INF   = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TILES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [LOG_GVT_PERIOD-1:0] CNT_ONE = LOG_GVT_PERIOD'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    // The scan plus publish must fit inside one period so a tick never
    // lands outside IDLE in a legal build.
    generate
        if (N_TILES < 1 || (N_TILES + 2) > (1 << LOG_GVT_PERIOD)) begin : g_bad_cfg
            $error("gvt_arbiter: N_TILES + 2 must not exceed 2^LOG_GVT_PERIOD");
        end
    endgenerate

    // Smaller of two virtual times (unsigned compare over {ts, tb}).
    function automatic logic [VT_W-1:0] vt_min(input logic [VT_W-1:0] a,
                                               input logic [VT_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [LOG_GVT_PERIOD-1:0] per_cnt_q, per_cnt_d;
    logic [1:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      tick;

    logic [VT_W-1:0]           lvt_vt [N_TILES];
    logic [VT_W-1:0]           snap_vt_q [N_TILES];
    logic [N_TILES-1:0]        snap_vld_q;
    logic [VT_W-1:0]           scan_vt;
    logic [VT_W-1:0]           acc_q;

    logic [VT_W-1:0]           gvt_vt_q;
    logic                      all_idle_q;
    logic                      acc_is_inf;
    logic                      publish;
    logic                      mono_fail;
    logic                      gvt_upd;

    // Join each tile's timestamp and tiebreaker into one comparable VT.
    for (genvar g = 0; g < N_TILES; g++) begin : g_unpack
        assign lvt_vt[g] = {lvt_ts[g*TS_WIDTH +: TS_WIDTH],
                            lvt_tb[g*TB_WIDTH +: TB_WIDTH]};
    end

    // Period counter: free-running while enabled, parked at 0 otherwise.
    always_comb begin
        per_cnt_d = enable ? (per_cnt_q + CNT_ONE) : '0;
    end

    assign tick = enable && (per_cnt_q == '1);

    // Round sequencing: IDLE waits for a tick, SCAN walks the tiles,
    // PUBLISH lasts one cycle. Ticks seen outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                idx_d = idx_q + IDX_ONE;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Select the snapshot entry addressed by idx; invalid tiles read as infinity.
    always_comb begin
        scan_vt = VT_INF;
        for (int i = 0; i < N_TILES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                scan_vt = snap_vld_q[i] ? snap_vt_q[i] : VT_INF;
            end
        end
    end

    // ---- stage: snapshot capture / serial min accumulation ----
    // Datapath registers carry no reset; they are always loaded on the tick
    // before being consumed, so live LVT changes cannot leak into a round.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && tick) begin
            for (int i = 0; i < N_TILES; i++) begin
                snap_vt_q[i] <= lvt_vt[i];
            end
            snap_vld_q <= lvt_valid;
            acc_q      <= VT_INF;
        end else if (state_q == ST_SCAN) begin
            acc_q <= vt_min(acc_q, scan_vt);
        end
    end

    assign publish    = (state_q == ST_PUBLISH);
    assign acc_is_inf = (acc_q == VT_INF);

`ifdef GVT_MONOTONIC_CHECK_EN
    logic gvt_err_q;

    // A finite round result below the current GVT means time went backwards.
    assign mono_fail = publish && !acc_is_inf && (acc_q < gvt_vt_q);

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            gvt_err_q <= 1'b0;
        end else if (mono_fail) begin
            gvt_err_q <= 1'b1;
        end
    end

    assign gvt_err = gvt_err_q;
`else
    assign mono_fail = 1'b0;
    assign gvt_err   = 1'b0;
`endif

    assign gvt_upd = publish && !acc_is_inf && !mono_fail;

    // ---- stage: control state and published result ----
    // Reset discards any round in flight and restores the reset outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            per_cnt_q  <= '0;
            gvt_vt_q   <= '0;
            all_idle_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            per_cnt_q <= per_cnt_d;
            if (publish) begin
                all_idle_q <= acc_is_inf;
            end
            if (gvt_upd) begin
                gvt_vt_q <= acc_q;
            end
        end
    end

    // The pulse is qualified by rstn so a reset asserted during PUBLISH
    // never announces a discarded round.
    assign gvt_valid = rstn && gvt_upd;
    assign gvt_ts    = gvt_vt_q[VT_W-1:TB_WIDTH];
    assign gvt_tb    = gvt_vt_q[TB_WIDTH-1:0];
    assign all_idle  = all_idle_q;

endmodule
